// File: rtl/ifetch.sv
// Brainfuck-style instruction fetch unit: fetches bytes, handshakes them to decode, resolves brackets.
// Optional return stack for ']' enabled by defining IFETCH_STACK_EN; otherwise ']' always scans backward.
module ifetch #(
    parameter int ADDR_W      = 10,
    parameter int STACK_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [7:0]        imem_data,
    output logic [7:0]        ix,
    output logic              ix_valid,
    input  logic              ix_ready,
    input  logic              cell_zero,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_SCAN  = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic [2:0]        state;
    logic              fresh;      // first ISSUE cycle: imem_data is the live instruction
    logic [7:0]        ix_q;
    logic [ADDR_W-1:0] scan_addr;
    logic [ADDR_W-1:0] depth;
    logic              scan_fwd;
    logic              scan_ph;    // 0: address presented, 1: data valid

    logic is_stop, is_br, is_open;
    logic d_stop, d_br, d_open, d_nest, scan_done, scan_edge;

    assign ix        = fresh ? imem_data : ix_q;
    assign ix_valid  = (state == S_ISSUE);
    assign imem_addr = (state == S_SCAN) ? scan_addr : pc;

    assign is_stop = (ix == 8'hFF);
    assign is_br   = (ix[3:1] == 3'b100);
    assign is_open = ~ix[0];

    assign d_stop    = (imem_data == 8'hFF);
    assign d_br      = (imem_data[3:1] == 3'b100);
    assign d_open    = ~imem_data[0];
    assign d_nest    = d_br && (d_open == scan_fwd);
    assign scan_done = d_br && (d_open != scan_fwd) && (depth == ADDR_ONE);
    assign scan_edge = scan_fwd ? (scan_addr == ADDR_MAX) : (scan_addr == '0);

`ifdef IFETCH_STACK_EN
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    logic [ADDR_W-1:0] stack [STACK_DEPTH];
    logic [SP_W-1:0]   sp;
    logic [IDX_W-1:0]  push_idx, top_idx;
    logic              push_en;

    assign push_idx = IDX_W'(sp);
    assign top_idx  = IDX_W'(sp - 1'b1);
    assign push_en  = (state == S_ISSUE) && ix_ready && !is_stop && is_br && is_open
                      && !cell_zero && (sp != SP_FULL);

    always_ff @(posedge clk) begin
        if (!rst && push_en)
            stack[push_idx] <= pc;
    end
`else
    logic unused_stack_cfg;
    assign unused_stack_cfg = (STACK_DEPTH > 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= '0;
            fresh     <= 1'b0;
            ix_q      <= 8'h00;
            halted    <= 1'b0;
            err       <= 1'b0;
            scan_addr <= '0;
            depth     <= '0;
            scan_fwd  <= 1'b0;
            scan_ph   <= 1'b0;
`ifdef IFETCH_STACK_EN
            sp        <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_FETCH;
                        pc    <= '0;
                    end
                end
                S_FETCH: begin
                    state <= S_ISSUE;
                    fresh <= 1'b1;
                end
                S_ISSUE: begin
                    fresh <= 1'b0;
                    if (fresh)
                        ix_q <= imem_data;
                    if (is_stop) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else if (ix_ready) begin
                        if (!is_br) begin
                            pc    <= pc + 1'b1;
                            state <= S_FETCH;
                        end else if (is_open) begin
                            if (cell_zero) begin
                                if (pc == ADDR_MAX) begin
                                    state <= S_HALT; halted <= 1'b1; err <= 1'b1;
                                end else begin
                                    scan_fwd  <= 1'b1;
                                    scan_addr <= pc + 1'b1;
                                    depth     <= ADDR_ONE;
                                    scan_ph   <= 1'b0;
                                    state     <= S_SCAN;
                                end
                            end else begin
`ifdef IFETCH_STACK_EN
                                if (sp == SP_FULL) begin
                                    state <= S_HALT; halted <= 1'b1; err <= 1'b1;
                                end else begin
                                    sp    <= sp + 1'b1;
                                    pc    <= pc + 1'b1;
                                    state <= S_FETCH;
                                end
`else
                                pc    <= pc + 1'b1;
                                state <= S_FETCH;
`endif
                            end
                        end else begin
`ifdef IFETCH_STACK_EN
                            // ']' peeks on a loop-back and pops on exit
                            if (sp == '0) begin
                                state <= S_HALT; halted <= 1'b1; err <= 1'b1;
                            end else if (!cell_zero) begin
                                pc    <= stack[top_idx] + 1'b1;
                                state <= S_FETCH;
                            end else begin
                                sp    <= sp - 1'b1;
                                pc    <= pc + 1'b1;
                                state <= S_FETCH;
                            end
`else
                            if (cell_zero) begin
                                pc    <= pc + 1'b1;
                                state <= S_FETCH;
                            end else if (pc == '0) begin
                                state <= S_HALT; halted <= 1'b1; err <= 1'b1;
                            end else begin
                                scan_fwd  <= 1'b0;
                                scan_addr <= pc - 1'b1;
                                depth     <= ADDR_ONE;
                                scan_ph   <= 1'b0;
                                state     <= S_SCAN;
                            end
`endif
                        end
                    end
                end
                S_SCAN: begin
                    // pc stays on the originating bracket until the match is found
                    if (!scan_ph) begin
                        scan_ph <= 1'b1;
                    end else begin
                        scan_ph <= 1'b0;
                        if (d_stop) begin
                            state <= S_HALT; halted <= 1'b1; err <= 1'b1;
                        end else if (scan_done) begin
                            pc    <= scan_addr + 1'b1;
                            depth <= '0;
                            state <= S_FETCH;
                        end else if (scan_edge) begin
                            state <= S_HALT; halted <= 1'b1; err <= 1'b1;
                        end else begin
                            scan_addr <= scan_fwd ? scan_addr + 1'b1 : scan_addr - 1'b1;
                            if (d_br)
                                depth <= d_nest ? depth + 1'b1 : depth - 1'b1;
                        end
                    end
                end
                S_HALT: ;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: program table plus hand sequences for timing, stall, wrap and reset.
module tb_ifetch;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst, start, ix_ready, cell_zero;
    logic [AW-1:0] imem_addr, pc;
    logic [7:0]    imem_data, ix;
    logic          ix_valid, halted, err;
    logic [7:0]    mem [16];
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) imem_data <= mem[imem_addr];

    ifetch #(.ADDR_W(AW), .STACK_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .start(start), .imem_addr(imem_addr), .imem_data(imem_data),
        .ix(ix), .ix_valid(ix_valid), .ix_ready(ix_ready), .cell_zero(cell_zero),
        .pc(pc), .halted(halted), .err(err)
    );

    typedef struct {
        string        name;
        logic [127:0] prog;   // byte i at [8i+:8]
        logic [7:0]   cz;     // cell_zero for the i-th branch handshake
        int           n;      // number of handshakes expected
        logic [63:0]  pcs;    // nibble i = pc of i-th handshake
        logic         exp_err;
        logic [AW-1:0] fpc;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [127:0] p);
        for (int i = 0; i < 16; i++) mem[i] = p[8*i +: 8];
    endtask

    task automatic do_reset;
        rst = 1'b1; start = 1'b0; ix_ready = 1'b1; cell_zero = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int nis = 0;
        int bidx = 0;
        logic [63:0] got = '0;
        do_reset;
        load(v.prog);
        pulse_start;
        for (int cyc = 0; cyc < 200 && !halted; cyc++) begin
            cell_zero = v.cz[bidx & 7];
            if (ix_valid && ix_ready) begin
                if (nis < 16) got[4*nis +: 4] = pc;
                nis++;
                if (ix[3:1] == 3'b100) bidx++;
            end
            @(negedge clk);
        end
        chk({v.name, " halted"}, 64'(halted), 64'd1);
        chk({v.name, " count"}, 64'(nis), 64'(v.n));
        chk({v.name, " pcs"}, got, v.pcs);
        chk({v.name, " err"}, 64'(err), 64'(v.exp_err));
        chk({v.name, " pc"}, 64'(pc), 64'(v.fpc));
    endtask

    initial begin
        int nis;
        logic [AW-1:0] wrap_pcs [17];

        vecs[0] = '{"plus", 128'hFF2B2B, 8'h00, 3, 64'h210, 1'b0, 4'd2};
        vecs[1] = '{"loop", 128'hFF090208, 8'b100, 6, 64'h321210, 1'b0, 4'd3};
        vecs[2] = '{"skip", 128'hFF2B09090808, 8'b1, 3, 64'h540, 1'b0, 4'd5};
        vecs[3] = '{"scan stop", 128'hFF0208, 8'b1, 1, 64'h0, 1'b1, 4'd0};
        vecs[4] = '{"close underflow", 128'hFF09, 8'h00, 1, 64'h0, 1'b1, 4'd0};
`ifdef IFETCH_STACK_EN
        vecs[5] = '{"stack overflow", 128'h080808, 8'h00, 3, 64'h210, 1'b1, 4'd2};
`else
        vecs[5] = '{"open no stack", 128'hFF080808, 8'h00, 4, 64'h3210, 1'b0, 4'd3};
`endif
        vecs[6] = '{"scan top edge", 128'h08 << 120, 8'b1, 16, 64'hFEDCBA9876543210, 1'b1, 4'd15};

        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        do_reset;
        chk("reset outputs", 64'({pc, imem_addr, ix, ix_valid, halted, err}), 64'd0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // halted rises six cycles after the start-sampling edge
        do_reset;
        load(128'hFF2B2B);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("timing halted c5", 64'(halted), 64'd0);
        @(negedge clk);
        chk("timing halted c6", 64'(halted), 64'd1);
        chk("timing valid c6", 64'(ix_valid), 64'd0);
        chk("timing err c6", 64'(err), 64'd0);

        // stall: ix and pc hold while ix_ready is low; start is ignored
        do_reset;
        load(128'hFF2B2B);
        ix_ready = 1'b0;
        pulse_start;
        for (int i = 0; i < 10 && !ix_valid; i++) @(negedge clk);
        chk("stall valid", 64'(ix_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            chk("stall hold", 64'({ix_valid, ix, pc}), 64'({1'b1, 8'h2B, 4'd0}));
            start = (i == 2);
            @(negedge clk);
        end
        start = 1'b0;
        ix_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("stall next", 64'({ix_valid, pc}), 64'({1'b1, 4'd1}));

        // pc wraps from the top address back to 0 without error
        do_reset;
        load(128'h0);
        pulse_start;
        nis = 0;
        for (int cyc = 0; cyc < 80 && nis < 17; cyc++) begin
            if (ix_valid && ix_ready) begin
                wrap_pcs[nis] = pc;
                nis++;
            end
            @(negedge clk);
        end
        chk("wrap count", 64'(nis), 64'd17);
        chk("wrap top", 64'(wrap_pcs[15]), 64'd15);
        chk("wrap zero", 64'(wrap_pcs[16]), 64'd0);
        chk("wrap err", 64'(err), 64'd0);

        // reset in the middle of a forward scan
        do_reset;
        load(128'h08);
        cell_zero = 1'b1;
        pulse_start;
        for (int i = 0; i < 10 && !ix_valid; i++) @(negedge clk);
        chk("scan issue", 64'({ix_valid, ix}), 64'({1'b1, 8'h08}));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("scan no valid", 64'({ix_valid, halted}), 64'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("scan reset outputs", 64'({pc, imem_addr, ix, ix_valid, halted, err}), 64'd0);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter ADDR_W, default 10, program memory address width.
REQ-002 Parameter STACK_DEPTH, default 16, loop-return stack entries.
REQ-003 Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; starts execution from IDLE.
- imem_addr  out  ADDR_W  program memory read address.
- imem_data  in  8  program byte; valid the cycle after imem_addr is presented.
- ix  out  8  instruction byte for the decode stage.
- ix_valid  out  1  ix holds an instruction.
- ix_ready  in  1  decode stage accepts ix.
- cell_zero  in  1  current data cell equals zero; sampled only at a branch handshake.
- pc  out  ADDR_W  address of the instruction held in ix.
- halted  out  1  stop byte reached or error; sticky.
- err  out  1  fault (stack over/underflow, unmatched bracket); sticky.

Function
REQ-004 Opcode classes use ix[3:1]: 3'b100 is branch; ix[0]=0 is open '[', ix[0]=1 is close ']'; 8'hFF is stop; all other bytes are ordinary.
REQ-005 The FSM SHALL have states IDLE, FETCH, ISSUE, SCAN, HALT.
REQ-006 IDLE: start moves to FETCH with pc=0; start is ignored in every other state.
REQ-007 FETCH: drive imem_addr=pc for one cycle, then go to ISSUE. In ISSUE, ix is loaded from imem_data and ix_valid=1 in the same cycle.
REQ-008 ISSUE: ix, ix_valid and pc are held stable until ix_valid&ix_ready; the handshake completes in that cycle.
REQ-009 Ordinary byte at handshake: pc<=pc+1 and go to FETCH. Best case is one instruction per 2 cycles.
REQ-010 Stop byte: the ifetch SHALL NOT wait for ix_ready. halted=1, ix_valid=0 on the next cycle, go to HALT, pc unchanged.
REQ-011 Open at handshake with cell_zero=1: go to SCAN forward with depth=1, starting at pc+1.
REQ-012 Open at handshake with cell_zero=0: push pc (stack mode), pc<=pc+1.
REQ-013 Close at handshake with cell_zero=0: stack mode sets pc<=top+1 with the stack unchanged; scan mode goes to SCAN backward with depth=1, starting at pc-1.
REQ-014 Close at handshake with cell_zero=1: stack mode pops; both modes set pc<=pc+1.
REQ-015 SCAN issues one byte read per 2 cycles and never asserts ix_valid.
- Forward scan: '[' depth+1, ']' depth-1. At depth 0, pc<=match+1 and go to FETCH.
- Backward scan: ']' depth+1, '[' depth-1. At depth 0, pc<=match+1 and go to FETCH.
- Depth counter width is ADDR_W.
REQ-016 During SCAN, reading a stop byte, or an address crossing 0 or 2^ADDR_W-1, SHALL set err=1 and halted=1, then go to HALT.
REQ-017 Push with STACK_DEPTH entries already full, or pop/peek on an empty stack, SHALL set err=1 and halted=1, go to HALT, and leave pc on the faulting instruction.
REQ-018 Normal pc increment past 2^ADDR_W-1 wraps to 0 with no error.
REQ-019 HALT is terminal until rst; outputs are held except ix_valid=0.

Reset
REQ-020 rst dominates all inputs, including mid-SCAN and mid-handshake.
REQ-021 On rst the state SHALL be IDLE and pc=0, imem_addr=0, ix=0, ix_valid=0, halted=0, err=0. The stack pointer and depth SHALL be 0.

Configuration
REQ-022 With IFETCH_STACK_EN defined, ']' uses the STACK_DEPTH-entry return stack per REQ-012/013/014/017.
REQ-023 Without IFETCH_STACK_EN, the stack is not built, '[' with cell_zero=0 only increments pc, ']' always uses backward SCAN, and stack errors cannot occur.

Verification
REQ-024 Program 2B 2B FF, ix_ready=1, start -> ix 2B at pc 0, then 2B at pc 1; halted=1 at cycle 6, err=0.
REQ-025 Program 08 02 09 FF with cell_zero=0,0,1 at successive branch handshakes -> issue order pc 0,1,2,1,2,3; halted=1. Verify in both configurations.
REQ-026 Program 08 08 09 09 2B FF, cell_zero=1 at pc 0 -> next issued pc=4 (byte 2B), then halted=1.
REQ-027 Stack mode, STACK_DEPTH=2, program 08 08 08 with cell_zero=0 -> err=1 and halted=1 with pc=2.
REQ-028 ix_ready=0 for 5 cycles on a pending instruction -> ix and pc stable throughout. rst asserted mid-SCAN -> all outputs at reset values the next cycle.
